// File: rtl/ula_seq_nslice.sv
// Multi-cycle 74181-style ALU: one 4-bit slice per cycle, LSB first, registered carry chain.
// Latency accept->out_valid = WIDTH/4 cycles; result/flags held in DONE until out_ready.
module ula_seq_nslice #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             zero
);
  localparam int NSL = WIDTH / 4;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d, carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_out_q, c_out_d, a_eq_b_q, a_eq_b_d, zero_q, zero_d;

  logic             accept, last_slice;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [3:0]       sa, sb, sx, sy, sl_f;
  logic [4:0]       sum;
  logic             sl_c;

  assign accept     = in_valid && (state_q == IDLE);
  assign last_slice = (idx_q == IW'(NSL - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (last_slice) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Current slice of the latched operands
  always_comb begin
    a_sh = a_q >> {idx_q, 2'b00};
    b_sh = b_q >> {idx_q, 2'b00};
    sa   = a_sh[3:0];
    sb   = b_sh[3:0];
  end

  // One 4-bit 74181 slice; ONE is 4'hF per slice so the chained sum equals the full-width sum
  always_comb begin
    sx   = 4'h0;
    sy   = 4'h0;
    sl_f = 4'h0;
    sum  = 5'h0;
    sl_c = 1'b0;
    if (m_q) begin
      case (s_q)
        4'h0: sl_f = ~sa;
        4'h1: sl_f = ~(sa | sb);
        4'h2: sl_f = ~sa & sb;
        4'h3: sl_f = 4'h0;
        4'h4: sl_f = ~(sa & sb);
        4'h5: sl_f = ~sb;
        4'h6: sl_f = sa ^ sb;
        4'h7: sl_f = sa & ~sb;
        4'h8: sl_f = ~sa | sb;
        4'h9: sl_f = ~(sa ^ sb);
        4'hA: sl_f = sb;
        4'hB: sl_f = sa & sb;
        4'hC: sl_f = 4'hF;
        4'hD: sl_f = sa | ~sb;
        4'hE: sl_f = sa | sb;
        default: sl_f = sa;
      endcase
    end else begin
      case (s_q)
        4'h0: begin sx = sa;        sy = 4'h0;     end
        4'h1: begin sx = sa | sb;   sy = 4'h0;     end
        4'h2: begin sx = sa | ~sb;  sy = 4'h0;     end
        4'h3: begin sx = 4'hF;      sy = 4'h0;     end
        4'h4: begin sx = sa;        sy = sa & ~sb; end
        4'h5: begin sx = sa | sb;   sy = sa & ~sb; end
        4'h6: begin sx = sa;        sy = ~sb;      end
        4'h7: begin sx = sa & ~sb;  sy = 4'hF;     end
        4'h8: begin sx = sa;        sy = sa & sb;  end
        4'h9: begin sx = sa;        sy = sb;       end
        4'hA: begin sx = sa | ~sb;  sy = sa & sb;  end
        4'hB: begin sx = sa & sb;   sy = 4'hF;     end
        4'hC: begin sx = sa;        sy = sa;       end
        4'hD: begin sx = sa | sb;   sy = sa;       end
        4'hE: begin sx = sa | ~sb;  sy = sa;       end
        default: begin sx = sa;     sy = 4'hF;     end
      endcase
      sum  = {1'b0, sx} + {1'b0, sy} + {4'h0, carry_q};
      sl_f = sum[3:0];
      sl_c = sum[4];
    end
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    m_d      = m_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    f_d      = f_q;
    c_out_d  = c_out_q;
    a_eq_b_d = a_eq_b_q;
    zero_d   = zero_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      s_d     = s;
      m_d     = m;
      carry_d = c_in;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      for (int i = 0; i < NSL; i++) begin
        if (idx_q == IW'(i)) f_d[4*i +: 4] = sl_f;
      end
      carry_d = sl_c;
      idx_d   = idx_q + 1'b1;
      if (last_slice) begin
        c_out_d  = m_q ? 1'b0 : sl_c;
        zero_d   = (f_d == '0);
        a_eq_b_d = (a_q == b_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      f_q      <= '0;
      c_out_q  <= 1'b0;
      a_eq_b_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      f_q      <= f_d;
      c_out_q  <= c_out_d;
      a_eq_b_q <= a_eq_b_d;
      zero_q   <= zero_d;
    end
  end

  assign f      = f_q;
  assign c_out  = c_out_q;
  assign a_eq_b = a_eq_b_q;
  assign zero   = zero_q;
endmodule

// File: tb/tb_ula_seq_nslice.sv
// Scoreboard bench for ula_seq_nslice (WIDTH=16 main instance, WIDTH=4/32 regression instances).
module tb_ula_seq_nslice;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic [3:0]  s = '0;
  logic        m = 1'b0, c_in = 1'b0;
  logic        in_ready, out_valid, c_out, a_eq_b, zero;
  logic [15:0] f;

  logic        iv4 = 1'b0, ir4, ov4, c4, eq4, z4;
  logic [3:0]  a4 = '0, b4 = '0, f4;
  logic        iv32 = 1'b0, ir32, ov32, c32, eq32, z32;
  logic [31:0] a32 = '0, b32 = '0, f32;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] f;
    logic        c;
    logic        eq;
    logic        z;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  ula_seq_nslice #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .s(s), .m(m),
    .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready), .f(f), .c_out(c_out),
    .a_eq_b(a_eq_b), .zero(zero));
  ula_seq_nslice #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .s(s), .m(m),
    .c_in(c_in), .out_valid(ov4), .out_ready(1'b1), .f(f4), .c_out(c4), .a_eq_b(eq4), .zero(z4));
  ula_seq_nslice #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .s(s), .m(m),
    .c_in(c_in), .out_valid(ov32), .out_ready(1'b1), .f(f32), .c_out(c32), .a_eq_b(eq32),
    .zero(z32));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Full-width reference, independent of slicing
  function automatic logic [16:0] ref_alu(input logic [15:0] ra, rb, input logic [3:0] rs,
                                          input logic rm, rc);
    logic [15:0] x, y, one;
    one = 16'hFFFF;
    x = '0;
    y = '0;
    if (rm) begin
      case (rs)
        4'h0: x = ~ra;          4'h1: x = ~(ra | rb);  4'h2: x = ~ra & rb;  4'h3: x = 16'h0;
        4'h4: x = ~(ra & rb);   4'h5: x = ~rb;         4'h6: x = ra ^ rb;   4'h7: x = ra & ~rb;
        4'h8: x = ~ra | rb;     4'h9: x = ~(ra ^ rb);  4'hA: x = rb;        4'hB: x = ra & rb;
        4'hC: x = one;          4'hD: x = ra | ~rb;    4'hE: x = ra | rb;   default: x = ra;
      endcase
      return {1'b0, x};
    end
    case (rs)
      4'h0: begin x = ra;       y = 16'h0;    end
      4'h1: begin x = ra | rb;  y = 16'h0;    end
      4'h2: begin x = ra | ~rb; y = 16'h0;    end
      4'h3: begin x = one;      y = 16'h0;    end
      4'h4: begin x = ra;       y = ra & ~rb; end
      4'h5: begin x = ra | rb;  y = ra & ~rb; end
      4'h6: begin x = ra;       y = ~rb;      end
      4'h7: begin x = ra & ~rb; y = one;      end
      4'h8: begin x = ra;       y = ra & rb;  end
      4'h9: begin x = ra;       y = rb;       end
      4'hA: begin x = ra | ~rb; y = ra & rb;  end
      4'hB: begin x = ra & rb;  y = one;      end
      4'hC: begin x = ra;       y = ra;       end
      4'hD: begin x = ra | rb;  y = ra;       end
      4'hE: begin x = ra | ~rb; y = ra;       end
      default: begin x = ra;    y = one;      end
    endcase
    return {1'b0, x} + {1'b0, y} + {16'h0, rc};
  endfunction

  // Monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got f=0x%0h with empty scoreboard", f);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("f", 32'(f), 32'(e.f));
        chk("c_out", 32'(c_out), 32'(e.c));
        chk("a_eq_b", 32'(a_eq_b), 32'(e.eq));
        chk("zero", 32'(zero), 32'(e.z));
      end
    end
  end

  task automatic wait_lat(input int nsl);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 40);
    chk("latency", 32'(n - 1), 32'(nsl));
  endtask

  task automatic send(input logic [15:0] ta, tb, input logic [3:0] ts, input logic tm, tc,
                      input exp_t e);
    int n;
    @(posedge clk); #1;
    a = ta; b = tb; s = ts; m = tm; c_in = tc; in_valid = 1'b1;
    sb.push_back(e);
    n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n < 40), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_lat(4);
  endtask

  function automatic exp_t mk(input logic [15:0] ra, rb, input logic [3:0] rs, input logic rm, rc);
    logic [16:0] r;
    r = ref_alu(ra, rb, rs, rm, rc);
    return '{f: r[15:0], c: r[16], eq: (ra == rb), z: (r[15:0] == 16'h0)};
  endfunction

  task automatic aux_run(input int w, input logic [31:0] ta, tb, input logic [31:0] ef,
                         input logic ec, ez);
    int n;
    @(posedge clk); #1;
    s = 4'h9; m = 1'b0; c_in = 1'b0;
    if (w == 4) begin a4 = ta[3:0]; b4 = tb[3:0]; iv4 = 1'b1; end
    else begin a32 = ta; b32 = tb; iv32 = 1'b1; end
    @(posedge clk); #1;
    iv4 = 1'b0; iv32 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((w == 4) ? ov4 : ov32) && n < 40);
    chk("aux_latency", 32'(n - 1), 32'(w / 4));
    chk("aux_f", (w == 4) ? 32'(f4) : f32, ef);
    chk("aux_c_out", 32'((w == 4) ? c4 : c32), 32'(ec));
    chk("aux_zero", 32'((w == 4) ? z4 : z32), 32'(ez));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e2;
    int n;
    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_flags", {29'd0, c_out, a_eq_b, zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors, expected values worked by hand
    send(16'h00FF, 16'h0001, 4'h9, 1'b0, 1'b0, '{f: 16'h0100, c: 1'b0, eq: 1'b0, z: 1'b0});
    send(16'hFFFF, 16'h0001, 4'h9, 1'b0, 1'b0, '{f: 16'h0000, c: 1'b1, eq: 1'b0, z: 1'b1});
    send(16'h1234, 16'h1234, 4'h6, 1'b0, 1'b1, '{f: 16'h0000, c: 1'b1, eq: 1'b1, z: 1'b1});
    send(16'h1000, 16'h0000, 4'hF, 1'b0, 1'b0, '{f: 16'h0FFF, c: 1'b1, eq: 1'b0, z: 1'b0});
    send(16'hA5A5, 16'hFFFF, 4'h6, 1'b1, 1'b1, '{f: 16'h5A5A, c: 1'b0, eq: 1'b0, z: 1'b0});
    send(16'hBEEF, 16'hBEEF, 4'h3, 1'b1, 1'b0, '{f: 16'h0000, c: 1'b0, eq: 1'b1, z: 1'b1});
    send(16'h0FFF, 16'h0000, 4'h0, 1'b0, 1'b1, '{f: 16'h1000, c: 1'b0, eq: 1'b0, z: 1'b0});

    // All 32 (s,m) combinations against the full-width model
    for (int i = 0; i < 32; i++)
      send(16'hA5C3, 16'h3C96, 4'(i), i[4], 1'b1, mk(16'hA5C3, 16'h3C96, 4'(i), i[4], 1'b1));

    // Backpressure in DONE while a new op is offered
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'h1234, 16'h1111, 4'h9, 1'b0, 1'b0, '{f: 16'h2345, c: 1'b0, eq: 1'b0, z: 1'b0});
    @(posedge clk); #1;
    a = 16'h00F0; b = 16'h0F00; s = 4'hE; m = 1'b1; c_in = 1'b0; in_valid = 1'b1;
    e2 = '{f: 16'h0FF0, c: 1'b0, eq: 1'b0, z: 1'b0};
    sb.push_back(e2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_f", 32'(f), 32'h2345);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
    chk("idle_f_kept", 32'(f), 32'h2345);
    @(posedge clk); #1;
    chk("next_accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_lat(4);

    // Reset two cycles into RUN
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; s = 4'h9; m = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_f", 32'(f), 32'd0);
    chk("midrst_flags", {29'd0, c_out, a_eq_b, zero}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    a = 16'h00FF; b = 16'h0001; s = 4'h9; m = 1'b0; c_in = 1'b0; in_valid = 1'b1;
    sb.push_back('{f: 16'h0100, c: 1'b0, eq: 1'b0, z: 1'b0});
    @(posedge clk); #1;
    chk("post_rst_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_lat(4);

    // WIDTH=4 and WIDTH=32 regressions
    aux_run(4, 32'h7, 32'h1, 32'h8, 1'b0, 1'b0);
    aux_run(4, 32'hF, 32'h1, 32'h0, 1'b1, 1'b1);
    aux_run(32, 32'h000000FF, 32'h1, 32'h00000100, 1'b0, 1'b0);
    aux_run(32, 32'hFFFFFFFF, 32'h1, 32'h00000000, 1'b1, 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
